instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

- Writer-side counterpart to the main control decoder: turns RV32I instruction descriptors into 32-bit words and writes them sequentially into instruction memory.
- Holds the single-cycle core in reset while loading and releases it when the program is complete.
- Sits between the bench/boot source and the imem write port; encodes exactly the opcode classes the decoder recognises.

## Interface
- DEPTH, 64, instruction-memory capacity in words
- AW, 6, address width, log2(DEPTH)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load session; honoured only in IDLE, DONE, ERR
- invalid  in  1  descriptor valid
- inready  out  1  block accepts descriptor; transfer when invalid&inready at a rising edge
- cls  in  3  0 R-type, 1 I-alu, 2 load, 3 store, 4 branch, 5 jal, 6 jalr, 7 illegal
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3 ; funct7  in  7  function fields
- imm  in  32  signed byte immediate
- last  in  1  descriptor is final of program
- memwe  out  1  imem write strobe
- memaddr  out  AW  imem word address
- memwdata  out  32  encoded instruction
- corehold  out  1  holds core in reset
- done  out  1  program loaded, core released
- err  out  1  sticky session error
- count  out  AW+1  words written this session

## Operation
- Opcodes: R 0110011, I-alu 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111.
- R: funct7|rs2|rs1|funct3|rd|op.
- I-alu/load: imm[11:0]|rs1|funct3|rd|op.
- jalr: imm[11:0]|rs1|000|rd|op; funct3 forced to 0.
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
- B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Unused fields are ignored; immediates are truncated to field width without a range check.
- Errors on accept:
  - cls=7
  - branch/jal with imm[0]=1
  - count==DEPTH
- On error: nothing is written, err is set, FSM goes to ERR.
- FSM states: IDLE, LOAD, WRITE, DONE, ERR.
  - IDLE: start -> LOAD.
  - LOAD: inready=1; accept -> WRITE, or ERR on error.
  - WRITE: memwe=1 for exactly one cycle; count increments; -> DONE if latched last, else LOAD.
  - DONE: corehold=0, done=1; start -> LOAD.
  - ERR: corehold=1, err=1; start -> LOAD and clears err.
- Entering LOAD from start: count<=0, err<=0, done<=0, corehold<=1.
- start in LOAD/WRITE is ignored.
- Reset values: state IDLE, corehold=1, inready=0, memwe=0, done=0, err=0, count=0, memaddr=0, memwdata=0.

## Timing
- All outputs are registered.
- Descriptor accepted at edge N: memwe, memaddr=count, and memwdata are valid during cycle N+1; count increments at edge N+2.
- Throughput is one descriptor per 2 cycles; inready=0 in WRITE.
- done rises and corehold falls in the cycle after the last write cycle.
- memaddr and memwdata hold their value after a write.
- Error detected at accept edge N: err=1 from cycle N+1; memwe never asserts for that descriptor.
- rst wins over everything. A descriptor accepted on the same edge rst is high is discarded. rst mid-session returns to IDLE with memwe=0 next cycle. Already-written memory is not cleared.

## Test plan
- add x3,x1,x2 (cls0, rd3, rs1 1, rs2 2, f3 0, f7 0, last) -> memwe one cycle, addr 0, data 0x002081B3, done=1, corehold=0, count=1.
- lw x5,8(x2) then sw x5,12(x2) with last -> 0x00812283 @0, 0x00512623 @1, count=2, memwe low between writes.
- beq x1,x2,-8 then jal x1,+16 -> 0xFE208CE3 @0, 0x010000EF @1.
- cls=7, then separately jal imm=3 -> err=1, no memwe, corehold=1, count unchanged; start -> err=0, count=0.
- DEPTH=4, five descriptors with last on the fifth -> four writes @0..3, fifth sets err, count=4, done=0.
- rst high on the accept edge of the second descriptor -> no second write, IDLE, corehold=1, count=0, memwe=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes RV32I instruction descriptors and writes them
// sequentially into instruction memory while holding the core in reset.
module instr_encoder_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          invalid,
    output logic          inready,
    input  logic [2:0]    cls,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [31:0]   imm,
    input  logic          last,
    output logic          memwe,
    output logic [AW-1:0] memaddr,
    output logic [31:0]   memwdata,
    output logic          corehold,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count
);

    localparam int unsigned CW = AW + 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            corehold_q, corehold_d;
    logic            inready_q, inready_d;
    logic            memwe_q, memwe_d;
    logic [AW-1:0]   memaddr_q, memaddr_d;
    logic [31:0]     memwdata_q, memwdata_d;
    logic            last_q, last_d;

    logic [31:0]     enc_word;
    logic            enc_bad;
    logic            unused_imm_hi;

    // Upper immediate bits beyond any field width are intentionally dropped.
    assign unused_imm_hi = ^imm[31:21];

    // Combinational encoder: descriptor fields to instruction word plus class error.
    always_comb begin
        enc_word = 32'd0;
        enc_bad  = 1'b0;
        case (cls)
            3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, OP_R};
            3'd1: enc_word = {imm[11:0], rs1, funct3, rd, OP_I};
            3'd2: enc_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            3'd3: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            3'd4: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                enc_bad  = imm[0];
            end
            3'd5: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                enc_bad  = imm[0];
            end
            3'd6: enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            default: enc_bad = 1'b1;
        endcase
    end

    // Next-state and registered-output logic for the load session.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        err_d      = err_q;
        done_d     = done_q;
        corehold_d = corehold_q;
        memwe_d    = 1'b0;
        memaddr_d  = memaddr_q;
        memwdata_d = memwdata_q;
        last_d     = last_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    count_d    = '0;
                    err_d      = 1'b0;
                    done_d     = 1'b0;
                    corehold_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (invalid && inready_q) begin
                    if (enc_bad || (count_q == CW'(DEPTH))) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = S_WRITE;
                        memwe_d    = 1'b1;
                        memaddr_d  = count_q[AW-1:0];
                        memwdata_d = enc_word;
                        last_d     = last;
                    end
                end
            end
            S_WRITE: begin
                count_d = count_q + CW'(1);
                if (last_q) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    corehold_d = 1'b0;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        inready_d = (state_d == S_LOAD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            corehold_q <= 1'b1;
            inready_q  <= 1'b0;
            memwe_q    <= 1'b0;
            memaddr_q  <= '0;
            memwdata_q <= 32'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_q      <= err_d;
            done_q     <= done_d;
            corehold_q <= corehold_d;
            inready_q  <= inready_d;
            memwe_q    <= memwe_d;
            memaddr_q  <= memaddr_d;
            memwdata_q <= memwdata_d;
            last_q     <= last_d;
        end
    end

    assign inready  = inready_q;
    assign memwe    = memwe_q;
    assign memaddr  = memaddr_q;
    assign memwdata = memwdata_q;
    assign corehold = corehold_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed program cases plus
// randomized programs checked against a field-shifting reference encoder.
module tb_instr_encoder_loader;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          invalid = 1'b0;
    logic          inready;
    logic [2:0]    cls = 3'd0;
    logic [4:0]    rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]    funct3 = 3'd0;
    logic [6:0]    funct7 = 7'd0;
    logic [31:0]   imm = 32'd0;
    logic          last = 1'b0;
    logic          memwe;
    logic [AW-1:0] memaddr;
    logic [31:0]   memwdata;
    logic          corehold, done, err;
    logic [AW:0]   count;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_count = 0;

    typedef struct {
        logic [2:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } desc_t;

    instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .invalid(invalid), .inready(inready),
        .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .last(last), .memwe(memwe), .memaddr(memaddr), .memwdata(memwdata),
        .corehold(corehold), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference encoder: place each field at its bit offset by shifting and masking.
    function automatic logic [31:0] enc_ref(input desc_t d);
        logic [31:0] im, w;
        im = d.imm;
        w  = 32'd0;
        case (d.cls)
            3'd0: w = (32'(d.f7) << 25) | (32'(d.rs2) << 20) | (32'(d.rs1) << 15)
                    | (32'(d.f3) << 12) | (32'(d.rd) << 7) | 32'h33;
            3'd1: w = ((im & 32'hFFF) << 20) | (32'(d.rs1) << 15) | (32'(d.f3) << 12)
                    | (32'(d.rd) << 7) | 32'h13;
            3'd2: w = ((im & 32'hFFF) << 20) | (32'(d.rs1) << 15) | (32'(d.f3) << 12)
                    | (32'(d.rd) << 7) | 32'h03;
            3'd3: w = (((im >> 5) & 32'h7F) << 25) | (32'(d.rs2) << 20) | (32'(d.rs1) << 15)
                    | (32'(d.f3) << 12) | ((im & 32'h1F) << 7) | 32'h23;
            3'd4: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                    | (32'(d.rs2) << 20) | (32'(d.rs1) << 15) | (32'(d.f3) << 12)
                    | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
            3'd5: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                    | (32'(d.rd) << 7) | 32'h6F;
            3'd6: w = ((im & 32'hFFF) << 20) | (32'(d.rs1) << 15) | (32'(d.rd) << 7) | 32'h67;
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic desc_t mk(input int c, input int rdv, input int r1, input int r2,
                                 input int f3v, input int f7v, input logic [31:0] iv);
        desc_t d;
        d.cls = 3'(c); d.rd = 5'(rdv); d.rs1 = 5'(r1); d.rs2 = 5'(r2);
        d.f3 = 3'(f3v); d.f7 = 7'(f7v); d.imm = iv;
        return d;
    endfunction

    function automatic desc_t rand_desc();
        desc_t d;
        d.cls = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        d.rd  = 5'($urandom); d.rs1 = 5'($urandom); d.rs2 = 5'($urandom);
        d.f3  = 3'($urandom); d.f7  = 7'($urandom); d.imm = $urandom;
        if ($urandom_range(0, 4) != 0) d.imm[0] = 1'b0;
        return d;
    endfunction

    function automatic bit desc_is_err(input desc_t d, input int cnt);
        return (d.cls == 3'd7) || ((d.cls == 3'd4 || d.cls == 3'd5) && d.imm[0])
               || (cnt == int'(DEPTH));
    endfunction

    task automatic start_session();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_count = 0;
        check_eq("start_count", 32'(count), 32'd0);
        check_eq("start_err", 32'(err), 32'd0);
        check_eq("start_done", 32'(done), 32'd0);
        check_eq("start_corehold", 32'(corehold), 32'd1);
        check_eq("start_inready", 32'(inready), 32'd1);
    endtask

    // Present one descriptor, wait for acceptance, and check the write or error outcome.
    task automatic send(input desc_t d, input logic is_last, output bit was_err);
        int waited;
        bit exp_err;
        exp_err = desc_is_err(d, exp_count);
        cls = d.cls; rd = d.rd; rs1 = d.rs1; rs2 = d.rs2;
        funct3 = d.f3; funct7 = d.f7; imm = d.imm; last = is_last;
        invalid = 1'b1;
        waited = 0;
        while (!inready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!inready) begin
            check_eq("inready_timeout", 32'(inready), 32'd1);
            invalid = 1'b0;
            was_err = 1'b1;
            return;
        end
        @(posedge clk); #1;
        invalid = 1'b0;
        last = 1'b0;
        if (exp_err) begin
            check_eq("err_set", 32'(err), 32'd1);
            check_eq("err_no_we", 32'(memwe), 32'd0);
            check_eq("err_corehold", 32'(corehold), 32'd1);
            @(posedge clk); #1;
            check_eq("err_no_we2", 32'(memwe), 32'd0);
            check_eq("err_count", 32'(count), 32'(exp_count));
            check_eq("err_done", 32'(done), 32'd0);
        end else begin
            check_eq("we", 32'(memwe), 32'd1);
            check_eq("addr", 32'(memaddr), 32'(exp_count % int'(DEPTH)));
            check_eq("wdata", memwdata, enc_ref(d));
            check_eq("ready_in_write", 32'(inready), 32'd0);
            @(posedge clk); #1;
            exp_count++;
            check_eq("we_pulse", 32'(memwe), 32'd0);
            check_eq("count", 32'(count), 32'(exp_count));
            check_eq("wdata_hold", memwdata, enc_ref(d));
        end
        was_err = exp_err;
    endtask

    // Run a whole program; stop at the first descriptor the model flags as an error.
    task automatic run_program(input desc_t prog[$]);
        bit e;
        e = 1'b0;
        start_session();
        foreach (prog[i]) begin
            send(prog[i], (i == prog.size() - 1), e);
            if (e) break;
        end
        if (!e) begin
            check_eq("prog_done", 32'(done), 32'd1);
            check_eq("prog_corehold", 32'(corehold), 32'd0);
            check_eq("prog_err", 32'(err), 32'd0);
            check_eq("prog_count", 32'(count), 32'(prog.size()));
        end else begin
            check_eq("prog_err_sticky", 32'(err), 32'd1);
            check_eq("prog_err_corehold", 32'(corehold), 32'd1);
        end
    endtask

    initial begin
        desc_t p[$];
        desc_t d;
        bit e;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_corehold", 32'(corehold), 32'd1);
        check_eq("rst_inready", 32'(inready), 32'd0);
        check_eq("rst_memwe", 32'(memwe), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_memaddr", 32'(memaddr), 32'd0);
        check_eq("rst_memwdata", memwdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_inready", 32'(inready), 32'd0);

        // add x3,x1,x2
        p = {};
        p.push_back(mk(0, 3, 1, 2, 0, 0, 32'd0));
        run_program(p);
        check_eq("add_word", enc_ref(p[0]), 32'h002081B3);

        // lw x5,8(x2) ; sw x5,12(x2)
        p = {};
        p.push_back(mk(2, 5, 2, 0, 2, 0, 32'd8));
        p.push_back(mk(3, 0, 2, 5, 2, 0, 32'd12));
        run_program(p);
        check_eq("lw_word", enc_ref(p[0]), 32'h00812283);
        check_eq("sw_word", enc_ref(p[1]), 32'h00512623);

        // beq x1,x2,-8 ; jal x1,+16
        p = {};
        p.push_back(mk(4, 0, 1, 2, 0, 0, 32'hFFFF_FFF8));
        p.push_back(mk(5, 1, 0, 0, 0, 0, 32'd16));
        run_program(p);
        check_eq("beq_word", enc_ref(p[0]), 32'hFE208CE3);
        check_eq("jal_word", enc_ref(p[1]), 32'h010000EF);

        // Illegal class, then misaligned jal, each in its own session.
        p = {};
        p.push_back(mk(0, 1, 2, 3, 0, 0, 32'd0));
        p.push_back(mk(7, 1, 2, 3, 0, 0, 32'd0));
        run_program(p);
        check_eq("illegal_count", 32'(count), 32'd1);
        p = {};
        p.push_back(mk(5, 1, 0, 0, 0, 0, 32'd3));
        run_program(p);
        check_eq("jal_odd_count", 32'(count), 32'd0);
        start_session();

        // Capacity overflow: five descriptors into four words.
        p = {};
        for (int i = 0; i < 5; i++) p.push_back(mk(1, i + 1, i, 0, 0, 0, 32'(i * 4)));
        run_program(p);
        check_eq("ovf_count", 32'(count), 32'(DEPTH));
        check_eq("ovf_done", 32'(done), 32'd0);

        // Reset on the accept edge of the second descriptor discards it.
        start_session();
        send(mk(1, 1, 0, 0, 0, 0, 32'd1), 1'b0, e);
        d = mk(1, 2, 0, 0, 0, 0, 32'd2);
        cls = d.cls; rd = d.rd; rs1 = d.rs1; imm = d.imm; funct3 = d.f3; last = 1'b1;
        invalid = 1'b1;
        check_eq("rst_case_ready", 32'(inready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        invalid = 1'b0;
        last = 1'b0;
        check_eq("midrst_memwe", 32'(memwe), 32'd0);
        check_eq("midrst_count", 32'(count), 32'd0);
        check_eq("midrst_corehold", 32'(corehold), 32'd1);
        check_eq("midrst_inready", 32'(inready), 32'd0);
        @(posedge clk); #1;
        check_eq("midrst_memwe2", 32'(memwe), 32'd0);
        check_eq("midrst_idle", 32'(inready), 32'd0);

        // Randomized programs.
        for (int t = 0; t < 60; t++) begin
            int n;
            n = $urandom_range(1, 6);
            p = {};
            for (int i = 0; i < n; i++) p.push_back(rand_desc());
            run_program(p);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
